// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for synfifo.
// Issues FIFO reads and re-presents the returned words as a valid/ready stream.
// A 2-entry output buffer hides the FIFO's 1-cycle registered read latency.
// Optional feature: define FIFO_RDCTL_CNT_EN to add the word_cnt
// delivered-word counter and its CNT_W parameter.
module fifo_rd_ctrl #(
   parameter int unsigned WIDTH = 8
`ifdef FIFO_RDCTL_CNT_EN
   ,
   parameter int unsigned CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_ren,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
`ifdef FIFO_RDCTL_CNT_EN
   output logic             busy,
   output logic [CNT_W-1:0] word_cnt
`else
   output logic             busy
`endif
);

   // Buffer occupancy; the encoding equals the number of buffered words.
   typedef enum logic [1:0] {
      OCC0 = 2'd0,
      OCC1 = 2'd1,
      OCC2 = 2'd2
   } occ_t;

   occ_t             occ_q, occ_d;
   logic             pend_q;
   logic [WIDTH-1:0] buf0_q, buf0_d;
   logic [WIDTH-1:0] buf1_q, buf1_d;
   logic             pop;
   logic             push;
   logic [2:0]       level;

   assign pop     = m_valid & m_ready;
   assign push    = pend_q;
   assign m_valid = (occ_q != OCC0);
   assign m_data  = buf0_q;
   assign busy    = pend_q | m_valid;

   // Words that will be owned after this edge: buffered plus in flight, minus the one leaving.
   assign level = 3'({1'b0, occ_q}) + 3'(pend_q) - 3'(pop);

   // Read request; gated by rst so no read is issued while reset is held.
   always_comb begin
      fifo_ren = rst & en & ~fifo_empty & (level < 3'd2);
   end

   // Registered state: occupancy, in-flight flag and the two buffer entries.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q  <= OCC0;
         pend_q <= 1'b0;
         buf0_q <= '0;
         buf1_q <= '0;
      end else begin
         occ_q  <= occ_d;
         pend_q <= fifo_ren;
         buf0_q <= buf0_d;
         buf1_q <= buf1_d;
      end
   end

   // Next occupancy and buffer contents; buf0 always holds the oldest word.
   always_comb begin
      occ_d  = occ_q;
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      case (occ_q)
         OCC0: begin
            if (push) begin
               buf0_d = fifo_rdata;
               occ_d  = OCC1;
            end
         end
         OCC1: begin
            if (push && pop) begin
               buf0_d = fifo_rdata;
            end else if (push) begin
               buf1_d = fifo_rdata;
               occ_d  = OCC2;
            end else if (pop) begin
               occ_d  = OCC0;
            end
         end
         OCC2: begin
            if (pop) begin
               buf0_d = buf1_q;
               if (push) begin
                  buf1_d = fifo_rdata;
               end else begin
                  occ_d  = OCC1;
               end
            end
         end
         default: occ_d = OCC0;
      endcase
   end

`ifdef FIFO_RDCTL_CNT_EN
   // Delivered-word counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt <= '0;
      end else if (pop) begin
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized and directed bench for fifo_rd_ctrl with a
// queue-based FIFO model and a queue-based output buffer reference model.
module tb_fifo_rd_ctrl;
   localparam int unsigned WIDTH = 8;
`ifdef FIFO_RDCTL_CNT_EN
   localparam int unsigned CNT_W = 8;
   logic [CNT_W-1:0] word_cnt;
   int unsigned      mcnt;
`endif

   logic             clk;
   logic             rst;
   logic             en;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_rdata;
   logic             fifo_ren;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             busy;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int val_cnt = 0;

   logic [7:0] q[$];
   logic [7:0] mq[$];
   bit         mpend = 1'b0;
   bit         prev_busy = 1'b0;
   logic [7:0] got[$];
   logic [7:0] pushed[$];
   int         ren_cyc[$];
   int         hs_cyc[$];
   int         bfall[$];

`ifdef FIFO_RDCTL_CNT_EN
   fifo_rd_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
`else
   fifo_rd_ctrl #(.WIDTH(WIDTH)) dut (
`endif
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready),
`ifdef FIFO_RDCTL_CNT_EN
      .busy(busy), .word_cnt(word_cnt)
`else
      .busy(busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Synchronous FIFO with 1-cycle registered read data.
   always @(posedge clk) begin
      logic [7:0] w;
      if (fifo_ren && q.size() != 0) begin
         w = q.pop_front();
         fifo_rdata <= w;
         fifo_empty <= (q.size() == 0);
      end
   end

   // Reference model and per-cycle compare, sampled on the falling edge.
   always @(negedge clk) begin
      bit ev, er, eb, p;
      int lvl;
      if (!rst) begin
         mq.delete();
         mpend = 1'b0;
`ifdef FIFO_RDCTL_CNT_EN
         mcnt = 0;
`endif
      end
      ev  = (mq.size() != 0);
      p   = ev && m_ready;
      lvl = mq.size() + int'(mpend) - int'(p);
      er  = rst && en && !fifo_empty && (lvl < 2);
      eb  = mpend || ev;
      chk("fifo_ren", fifo_ren, er);
      chk("m_valid", m_valid, ev);
      chk("busy", busy, eb);
      chk("ren_when_empty", fifo_ren & fifo_empty, 0);
      if (ev) chk("m_data", m_data, mq[0]);
`ifdef FIFO_RDCTL_CNT_EN
      chk("word_cnt", word_cnt, mcnt % (1 << CNT_W));
`endif
      if (fifo_ren) ren_cyc.push_back(cyc);
      if (m_valid) val_cnt++;
      if (m_valid && m_ready) begin
         hs_cyc.push_back(cyc);
         got.push_back(m_data);
      end
      if (!busy && prev_busy) bfall.push_back(cyc);
      prev_busy = busy;
      if (rst) begin
         if (p) begin
            void'(mq.pop_front());
`ifdef FIFO_RDCTL_CNT_EN
            mcnt++;
`endif
         end
         if (mpend) begin
            chk("push_into_full", mq.size() < 2, 1);
            mq.push_back(fifo_rdata);
         end
         mpend = er;
      end
      cyc++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [7:0] w);
      q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic flush();
      q.delete();
      fifo_empty = 1'b1;
   endtask

   initial begin
      int rb, hb, gb, fb, vb;
      logic [7:0] w;
      rst = 1'b0; en = 1'b1; m_ready = 1'b1; fifo_empty = 1'b1; fifo_rdata = '0;
      load(8'h5A);

      // reset held with a non-empty FIFO and enable high
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("rst_ren", fifo_ren, 0);
         chk("rst_valid", m_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_data", m_data, 0);
      end
      flush(); en = 1'b0;
      step(1); rst = 1'b1; step(2);

      // full-rate stream of eight words
      rb = ren_cyc.size(); hb = hs_cyc.size(); gb = got.size(); fb = bfall.size();
      for (int i = 0; i < 8; i++) load(8'(8'h11 * (i + 1)));
      en = 1'b1; m_ready = 1'b1;
      step(20);
      chk("stream_ren_cnt", ren_cyc.size() - rb, 8);
      chk("stream_hs_cnt", hs_cyc.size() - hb, 8);
      if (ren_cyc.size() >= rb + 8 && hs_cyc.size() >= hb + 8) begin
         chk("stream_ren_consec", ren_cyc[rb+7] - ren_cyc[rb], 7);
         chk("stream_latency", hs_cyc[hb] - ren_cyc[rb], 2);
         chk("stream_hs_consec", hs_cyc[hb+7] - hs_cyc[hb], 7);
         if (bfall.size() > fb) chk("stream_busy_fall", bfall[fb], hs_cyc[hb+7] + 1);
         else chk("stream_busy_fall_seen", 0, 1);
      end
      for (int i = 0; i < 8; i++)
         if (got.size() > gb + i) chk("stream_data", got[gb+i], 8'h11 * (i + 1));
      chk("stream_busy_end", busy, 0);

      // backpressure: two reads fill the buffer, then stall
      rb = ren_cyc.size(); hb = hs_cyc.size(); gb = got.size();
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) load(8'(8'h11 * (i + 1)));
      step(10);
      chk("bp_ren_cnt", ren_cyc.size() - rb, 2);
      chk("bp_valid", m_valid, 1);
      chk("bp_data_held", m_data, 8'h11);
      m_ready = 1'b1;
      step(20);
      chk("bp_hs_cnt", hs_cyc.size() - hb, 8);
      for (int i = 0; i < 8; i++)
         if (got.size() > gb + i) chk("bp_data", got[gb+i], 8'h11 * (i + 1));

      // empty FIFO with enable high
      rb = ren_cyc.size(); vb = val_cnt;
      step(20);
      chk("empty_ren_cnt", ren_cyc.size() - rb, 0);
      chk("empty_valid_cnt", val_cnt - vb, 0);

      // enable dropped after three reads
      rb = ren_cyc.size(); hb = hs_cyc.size(); gb = got.size(); fb = bfall.size();
      en = 1'b0; step(1);
      for (int i = 0; i < 8; i++) load(8'(8'h11 * (i + 1)));
      en = 1'b1; step(3); en = 1'b0; step(12);
      chk("drop_ren_cnt", ren_cyc.size() - rb, 3);
      chk("drop_hs_cnt", hs_cyc.size() - hb, 3);
      for (int i = 0; i < 3; i++)
         if (got.size() > gb + i) chk("drop_data", got[gb+i], 8'h11 * (i + 1));
      if (hs_cyc.size() >= hb + 3 && bfall.size() > fb)
         chk("drop_busy_fall", bfall[fb], hs_cyc[hb+2] + 1);
      else chk("drop_busy_fall_seen", 0, 1);
      flush();

      // mid-operation reset with a full buffer
      en = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 8; i++) load(8'(8'h11 * (i + 1)));
      step(6);
      chk("mid_valid_pre", m_valid, 1);
      rst = 1'b0; #1;
      chk("mid_valid_rst", m_valid, 0);
      chk("mid_busy_rst", busy, 0);
      chk("mid_ren_rst", fifo_ren, 0);
      step(2);
      flush(); load(8'hA5);
      hb = hs_cyc.size(); gb = got.size();
      rst = 1'b1; m_ready = 1'b1;
      step(10);
      chk("mid_hs_cnt", hs_cyc.size() - hb, 1);
      if (got.size() > gb) chk("mid_first_data", got[gb], 8'hA5);

`ifdef FIFO_RDCTL_CNT_EN
      // counter wrap: 300 words into an 8-bit counter leaves 44
      rst = 1'b0; step(1); rst = 1'b1;
      hb = hs_cyc.size();
      for (int i = 0; i < 300; i++) load(8'(i));
      step(320);
      chk("cnt_hs", hs_cyc.size() - hb, 300);
      chk("cnt_wrap", word_cnt, 44);
`endif

      // randomized enable/backpressure/arrivals, then a full drain
      flush(); pushed.delete();
      gb = got.size();
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 1) == 1) begin
            w = 8'($urandom);
            load(w);
            pushed.push_back(w);
         end
         step(1);
      end
      en = 1'b1; m_ready = 1'b1;
      step(40);
      chk("rand_word_cnt", got.size() - gb, pushed.size());
      for (int i = 0; i < pushed.size(); i++)
         if (got.size() > gb + i) chk("rand_order", got[gb+i], pushed[i]);
      chk("rand_busy_end", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
